// File: rtl/branch_update_scheduler.sv
// Branch update scheduler: buffers resolved-branch updates from execute and
// arbitrates them against fetch lookups for the predictor's single port.
// Fetch normally wins, a starvation guard forces an update after a run of
// deferred cycles, and a drain request flushes everything pending.
module branch_update_scheduler #(
  parameter int DEPTH        = 4,
  parameter int PC_W         = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int STAT_W       = 16,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_res_valid,
  output logic              o_res_ready,
  input  logic [PC_W-1:0]   i_res_pc,
  input  logic              i_res_outcome,
  input  logic              i_res_predicted,
  input  logic              i_lookup_req,
  output logic              o_lookup_grant,
  output logic              o_upd_en,
  output logic [PC_W-1:0]   o_upd_pc,
  output logic              o_upd_outcome,
  input  logic              i_drain_req,
  output logic              o_drain_done,
  output logic [CNT_W-1:0]  o_queue_count,
  output logic [STAT_W-1:0] o_stat_updates,
  output logic [STAT_W-1:0] o_stat_mispredicts
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_FORCE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [SC_W-1:0]   r_starveCnt;
  logic [SC_W-1:0]   w_nextStarve;

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_countNext;
  logic [PC_W-1:0]   r_memPc   [DEPTH];
  logic              r_memOut  [DEPTH];
  logic              r_memPred [DEPTH];

  logic [STAT_W-1:0] r_statUpd;
  logic [STAT_W-1:0] r_statMis;

  logic w_resReady;
  logic w_grant;
  logic w_updEn;
  logic w_drainDone;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_notEmpty;
  logic w_headMis;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_notEmpty = (r_count != '0);
  assign w_headMis  = (r_memOut[r_rdPtr] != r_memPred[r_rdPtr]);

  // Port arbitration, FIFO handshake and next-state / starvation-counter decode
  always_comb begin
    w_resReady   = 1'b0;
    w_grant      = 1'b0;
    w_updEn      = 1'b0;
    w_drainDone  = 1'b0;
    w_nextState  = r_state;
    w_nextStarve = '0;
    if (i_reset) begin
      w_resReady = !w_full && (r_state != S_DRAIN);
      case (r_state)
        S_IDLE:  w_grant = i_lookup_req;
        S_PEND: begin
          w_grant = i_lookup_req;
          w_updEn = !i_lookup_req && w_notEmpty;
        end
        S_FORCE: w_updEn = w_notEmpty;
        S_DRAIN: w_updEn = w_notEmpty;
        S_DONE: begin
          w_grant     = i_lookup_req;
          w_drainDone = 1'b1;
        end
        default: ;
      endcase
    end
    w_push      = i_res_valid && w_resReady;
    w_pop       = w_updEn;
    w_countNext = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    case (r_state)
      S_IDLE: begin
        if (i_drain_req) begin
          w_nextState = w_push ? S_DRAIN : S_DONE;
        end else if (w_push) begin
          w_nextState = S_PEND;
        end
      end
      S_PEND: begin
        if (i_drain_req) begin
          w_nextState = (w_countNext == '0) ? S_DONE : S_DRAIN;
        end else if (w_countNext == '0) begin
          w_nextState = S_IDLE;
        end else if (i_lookup_req) begin
          if (r_starveCnt == SC_W'(STARVE_LIMIT - 1)) begin
            w_nextState = S_FORCE;
          end else begin
            w_nextStarve = r_starveCnt + SC_W'(1);
          end
        end
      end
      S_FORCE: w_nextState = (w_countNext != '0) ? S_PEND : S_IDLE;
      S_DRAIN: begin
        if (w_countNext == '0) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE:  w_nextState = (w_countNext != '0) ? S_PEND : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State and starvation counter registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_starveCnt <= '0;
    end else begin
      r_state     <= w_nextState;
      r_starveCnt <= w_nextStarve;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= w_countNext;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every use
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_memPc[r_wrPtr]   <= i_res_pc;
      r_memOut[r_wrPtr]  <= i_res_outcome;
      r_memPred[r_wrPtr] <= i_res_predicted;
    end
  end

  // Saturating statistics, counted when an update leaves the FIFO
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_statUpd <= '0;
      r_statMis <= '0;
    end else if (w_pop) begin
      if (r_statUpd != '1) begin
        r_statUpd <= r_statUpd + STAT_W'(1);
      end
      if (w_headMis && (r_statMis != '1)) begin
        r_statMis <= r_statMis + STAT_W'(1);
      end
    end
  end

  assign o_res_ready        = w_resReady;
  assign o_lookup_grant     = w_grant;
  assign o_upd_en           = w_updEn;
  assign o_upd_pc           = r_memPc[r_rdPtr];
  assign o_upd_outcome      = r_memOut[r_rdPtr];
  assign o_drain_done       = w_drainDone;
  assign o_queue_count      = r_count;
  assign o_stat_updates     = r_statUpd;
  assign o_stat_mispredicts = r_statMis;

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Scoreboard bench for branch_update_scheduler: accepted pushes queue their
// expected update, a negedge monitor pops and compares whenever upd_en fires,
// and directed cycle checks cover arbitration, starvation, drain and stats.
module tb_branch_update_scheduler;

  logic        clk = 1'b0;
  logic        rstN;
  logic        resValid;
  logic [31:0] resPc;
  logic        resOutcome;
  logic        resPredicted;
  logic        lookupReq;
  logic        drainReq;

  logic        resReady;
  logic        lookupGrant;
  logic        updEn;
  logic [31:0] updPc;
  logic        updOutcome;
  logic        drainDone;
  logic [2:0]  queueCount;
  logic [15:0] statUpdates;
  logic [15:0] statMispredicts;

  logic        sResReady;
  logic        sLookupGrant;
  logic        sUpdEn;
  logic [31:0] sUpdPc;
  logic        sUpdOutcome;
  logic        sDrainDone;
  logic [2:0]  sQueueCount;
  logic [1:0]  sStatUpdates;
  logic [1:0]  sStatMispredicts;

  typedef struct packed {
    logic [31:0] pc;
    logic        outcome;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_update_scheduler #(
    .DEPTH(4), .PC_W(32), .STARVE_LIMIT(3), .STAT_W(16)
  ) dut (
    .i_clk(clk), .i_reset(rstN),
    .i_res_valid(resValid), .o_res_ready(resReady), .i_res_pc(resPc),
    .i_res_outcome(resOutcome), .i_res_predicted(resPredicted),
    .i_lookup_req(lookupReq), .o_lookup_grant(lookupGrant),
    .o_upd_en(updEn), .o_upd_pc(updPc), .o_upd_outcome(updOutcome),
    .i_drain_req(drainReq), .o_drain_done(drainDone),
    .o_queue_count(queueCount),
    .o_stat_updates(statUpdates), .o_stat_mispredicts(statMispredicts)
  );

  // Narrow-statistics twin sharing all stimulus, used to observe saturation
  branch_update_scheduler #(
    .DEPTH(4), .PC_W(32), .STARVE_LIMIT(3), .STAT_W(2)
  ) dutSat (
    .i_clk(clk), .i_reset(rstN),
    .i_res_valid(resValid), .o_res_ready(sResReady), .i_res_pc(resPc),
    .i_res_outcome(resOutcome), .i_res_predicted(resPredicted),
    .i_lookup_req(lookupReq), .o_lookup_grant(sLookupGrant),
    .o_upd_en(sUpdEn), .o_upd_pc(sUpdPc), .o_upd_outcome(sUpdOutcome),
    .i_drain_req(drainReq), .o_drain_done(sDrainDone),
    .o_queue_count(sQueueCount),
    .o_stat_updates(sStatUpdates), .o_stat_mispredicts(sStatMispredicts)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then return at the negedge
  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic outcome, input logic predicted,
                               input logic lookup, input logic drain,
                               input logic accepted);
    exp_t e;
    @(posedge clk);
    #1;
    resValid     = valid;
    resPc        = pc;
    resOutcome   = outcome;
    resPredicted = predicted;
    lookupReq    = lookup;
    drainReq     = drain;
    if (valid && accepted) begin
      e.pc      = pc;
      e.outcome = outcome;
      expQ.push_back(e);
    end
    @(negedge clk);
  endtask

  // Hold reset low for the given cycles, checking outputs stay gated
  task automatic applyReset(input int cycles);
    @(posedge clk);
    #1;
    rstN      = 1'b0;
    resValid  = 1'b1;
    drainReq  = 1'b0;
    lookupReq = 1'b1;
    expQ.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput("rstReady", resReady, 0);
      checkOutput("rstGrant", lookupGrant, 0);
      checkOutput("rstUpdEn", updEn, 0);
      if (i < cycles - 1) @(posedge clk);
    end
    @(posedge clk);
    #1;
    rstN      = 1'b1;
    resValid  = 1'b0;
    lookupReq = 1'b0;
  endtask

  // Monitor: every issued update must match the oldest expected entry
  always @(negedge clk) begin
    if (rstN) begin
      checkOutput("exclusiveGrant", updEn & lookupGrant, 0);
      if (updEn) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedUpdate: got pc %0h expected no update at %0t", updPc, $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("updPc", updPc, e.pc);
          checkOutput("updOutcome", updOutcome, e.outcome);
        end
      end
    end
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; resValid = 1'b0; resPc = '0; resOutcome = 1'b0;
    resPredicted = 1'b0; lookupReq = 1'b1; drainReq = 1'b0;
    applyReset(2);

    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("rstCount", queueCount, 0);
    checkOutput("rstStatUpd", statUpdates, 0);
    checkOutput("rstStatMis", statMispredicts, 0);
    checkOutput("rstDrainDone", drainDone, 0);
    checkOutput("rstReadyOut", resReady, 1);

    $display("[TB] test 1: back-to-back pushes, no lookups");
    applyStimulus(1, 32'hA000, 1, 1, 0, 0, 1);
    checkOutput("t1UpdC1", updEn, 0);
    applyStimulus(1, 32'hB000, 0, 0, 0, 0, 1);
    checkOutput("t1UpdC2", updEn, 1);
    applyStimulus(1, 32'hC000, 1, 0, 0, 0, 1);
    checkOutput("t1UpdC3", updEn, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t1UpdC4", updEn, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t1UpdC5", updEn, 0);
    checkOutput("t1Count", queueCount, 0);

    $display("[TB] test 2: lookups held, starvation guard");
    applyStimulus(1, 32'hD000, 1, 1, 1, 0, 1);
    checkOutput("t2GrantC1", lookupGrant, 1);
    checkOutput("t2UpdC1", updEn, 0);
    applyStimulus(1, 32'hD001, 0, 0, 1, 0, 1);
    applyStimulus(1, 32'hD002, 1, 1, 1, 0, 1);
    applyStimulus(1, 32'hD003, 0, 1, 1, 0, 1);
    checkOutput("t2UpdDeferred", updEn, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t2ReadyFull", resReady, 0);
    checkOutput("t2CountFull", queueCount, 4);
    checkOutput("t2ForceUpd", updEn, 1);
    checkOutput("t2ForceGrant", lookupGrant, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t2CountAfterForce", queueCount, 3);
    checkOutput("t2UpdAfterForce", updEn, 0);
    checkOutput("t2GrantAfterForce", lookupGrant, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t2UpdThirdDefer", updEn, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t2Force2Upd", updEn, 1);
    checkOutput("t2Force2Grant", lookupGrant, 0);

    $display("[TB] test 3: drain from a full queue");
    applyStimulus(1, 32'hD004, 1, 1, 1, 0, 1);
    checkOutput("t2CountFinal", queueCount, 2);
    applyStimulus(1, 32'hD005, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    checkOutput("t3CountFull", queueCount, 4);
    checkOutput("t3UpdBeforeDrain", updEn, 0);
    applyStimulus(1, 32'hBAD0, 1, 1, 1, 0, 0);
    checkOutput("t3DrainUpd1", updEn, 1);
    checkOutput("t3DrainGrant1", lookupGrant, 0);
    checkOutput("t3DrainReady1", resReady, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t3DrainUpd2", updEn, 1);
    checkOutput("t3DrainGrant2", lookupGrant, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t3DrainUpd3", updEn, 1);
    checkOutput("t3DrainReady3", resReady, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t3DrainUpd4", updEn, 1);
    checkOutput("t3DrainDoneEarly", drainDone, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t3DrainDone", drainDone, 1);
    checkOutput("t3DoneGrant", lookupGrant, 1);
    checkOutput("t3DoneUpd", updEn, 0);
    checkOutput("t3DoneCount", queueCount, 0);
    checkOutput("t3DoneReady", resReady, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t3DrainDoneOff", drainDone, 0);
    checkOutput("t3IdleGrant", lookupGrant, 1);
    checkOutput("t3StatUpd", statUpdates, 9);
    checkOutput("t3StatMis", statMispredicts, 2);
    checkOutput("t3SatUpd", sStatUpdates, 3);
    checkOutput("t3SatMis", sStatMispredicts, 2);

    $display("[TB] test 5: reset mid-operation, drain while idle");
    applyStimulus(1, 32'hE000, 1, 1, 1, 0, 1);
    applyStimulus(1, 32'hE001, 1, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t5CountBefore", queueCount, 2);
    applyReset(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t5CountAfter", queueCount, 0);
    checkOutput("t5UpdAfter", updEn, 0);
    checkOutput("t5StatUpd", statUpdates, 0);
    checkOutput("t5StatMis", statMispredicts, 0);
    checkOutput("t5SatUpd", sStatUpdates, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("t5DoneU1", drainDone, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t5DoneU2", drainDone, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t5DoneU3", drainDone, 0);

    $display("[TB] test 4: mispredict statistics");
    applyStimulus(1, 32'hF000, 1, 0, 1, 0, 1);
    applyStimulus(1, 32'hF001, 1, 1, 1, 0, 1);
    applyStimulus(1, 32'hF002, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    checkOutput("t4CountDrain", queueCount, 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("t4DrainUpd", updEn, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t4DrainDone", drainDone, 1);
    checkOutput("t4SatDrainDone", sDrainDone, 1);
    checkOutput("t4StatUpd", statUpdates, 3);
    checkOutput("t4StatMis", statMispredicts, 2);
    checkOutput("t4SatUpd", sStatUpdates, 3);
    checkOutput("t4SatMis", sStatMispredicts, 2);

    $display("[TB] test 6: steady push and pop across pointer wrap");
    applyStimulus(1, 32'h6000, 1, 0, 1, 0, 1);
    applyStimulus(1, 32'h6001, 1, 0, 1, 0, 1);
    for (int i = 2; i < 8; i++) begin
      applyStimulus(1, 32'h6000 + 32'(i), 1, 0, 0, 0, 1);
      checkOutput("t6CountSteady", queueCount, 2);
      checkOutput("t6UpdSteady", updEn, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t6CountAfterRun", queueCount, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t6CountTail", queueCount, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("t6CountEmpty", queueCount, 0);
    checkOutput("t6UpdEmpty", updEn, 0);
    checkOutput("t6StatUpd", statUpdates, 11);
    checkOutput("t6StatMis", statMispredicts, 10);
    checkOutput("t6SatUpd", sStatUpdates, 3);
    checkOutput("t6SatMis", sStatMispredicts, 3);
    checkOutput("t6SatCount", sQueueCount, 0);
    checkOutput("t6SatUpdEn", sUpdEn, 0);
    checkOutput("t6SatReady", sResReady, 1);
    checkOutput("t6SatGrant", sLookupGrant, 0);
    checkOutput("scoreboardEmpty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
